branch_resolver: RTL
====================

# branch_resolver

Sequential branch/jump resolution stage for the single-cycle RISC-V core's pipelined variant. Consumes the ALU's subtract flags (Zero, Carry, Overflow, Negative) and its result, decodes the branch condition, computes the target, and drives a held redirect request plus a timed front-end flush under predict-not-taken. It sits downstream of the ALU as the reader of its condition flags.

## Interface
- XLEN, 32, datapath and PC width
- FLUSH_CYCLES, 2, cycles `flush` stays high after an accepted redirect (0 allowed)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  resolve request present
- in_ready  out  1  stage can accept (high only in IDLE)
- br_kind  in  2  00 none, 01 conditional branch, 10 jal, 11 jalr
- br_funct3  in  3  RISC-V branch funct3
- pc  in  XLEN  PC of the instruction
- imm  in  XLEN  sign-extended offset
- alu_result  in  XLEN  ALU sum (rs1+imm for jalr)
- flag_zero, flag_carry, flag_overflow, flag_negative  in  1 each  ALU flags from rs1−rs2
- redirect_valid  out  1  redirect request
- redirect_ready  in  1  front end accepts redirect
- redirect_pc  out  XLEN  target, stable while redirect_valid
- flush  out  1  squash younger instructions
- illegal_branch  out  1  one-cycle pulse, funct3 010/011 with br_kind 01

## Operation
- States: IDLE, RESOLVE, REDIRECT, FLUSH.
- IDLE: in_ready=1; in_valid&in_ready at an edge captures all inputs, goes to RESOLVE.
- RESOLVE (one cycle): taken for br_kind 01 per funct3: 000 Z; 001 ~Z; 100 N^V; 101 ~(N^V); 110 ~C; 111 C; 010/011 not taken plus illegal_branch pulse. br_kind 10/11 always taken; 00 never.
- Target: kinds 01/10 pc+imm; kind 11 {alu_result[XLEN-1:1],1'b0}. Addition modulo 2^XLEN (wrap, no error). Misaligned targets are passed through unchanged.
- Taken → REDIRECT; not taken → IDLE.
- REDIRECT: redirect_valid=1, redirect_pc held; transfer at edge where redirect_ready=1 → FLUSH (or IDLE if FLUSH_CYCLES=0).
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles via down-counter, then IDLE.
- rst at any time: state IDLE, all outputs 0 except in_ready=1 after release; in-flight request discarded; stat counters cleared.

## Timing
- All outputs registered/decoded from state registers; no combinational path input→output except none (in_ready from state only).
- Accept at edge E0; RESOLVE during E0→E1; redirect_valid high from E1; illegal_branch high during E1→E2.
- Untaken throughput: one request per 2 cycles.
- Taken with redirect_ready tied high: redirect_valid for one cycle (E1→E2), flush E2→E2+FLUSH_CYCLES, in_ready returns after that.
- redirect_pc must not change while redirect_valid=1 and redirect_ready=0.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: adds outputs stat_resolved (32, counts kind≠00 resolves) and stat_taken (32, counts entries to REDIRECT); both saturate at 32'hFFFF_FFFF, cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- beq, flag_zero=1, pc=0x100, imm=0x40 → redirect_valid one cycle after accept, redirect_pc=0x140; flush high 2 cycles; in_ready back after.
- blt with N=1,V=1 → not taken, no redirect/flush, in_ready=1 two cycles after accept; bltu with C=0 → taken.
- jalr, alu_result=0x0000_2003 → redirect_pc=0x0000_2002; jal pc=0xFFFF_FFF0, imm=0x20 → redirect_pc=0x10 (wrap).
- Taken branch with redirect_ready low 5 cycles → redirect_valid and redirect_pc stable all 5, flush only after ready; funct3=010 → illegal_branch one pulse, no redirect.
- Assert rst during REDIRECT → redirect_valid, flush drop immediately (async), in_ready=1 after release; with BRANCH_RESOLVER_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch/jump resolution stage: decodes the branch condition from ALU flags,
// drives a held redirect and a timed flush. Optional stats: BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      br_kind,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            flag_zero,
    input  logic            flag_carry,
    input  logic            flag_overflow,
    input  logic            flag_negative,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken,
`endif
    output logic            illegal_branch
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t          state_q;
    logic [1:0]      kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] alu_q;
    logic            z_q;
    logic            c_q;
    logic            v_q;
    logic            n_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;
    logic            illegal_q;

    logic            taken_d;
    logic            illegal_d;
    logic [XLEN-1:0] target_d;

    // jalr clears the target LSB, so the captured ALU bit 0 is never used
    logic            unused_alu_lsb;
    assign unused_alu_lsb = alu_q[0];

    // Branch condition and target decoded from the captured request
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        unique case (kind_q)
            2'b01: begin
                unique case (funct3_q)
                    3'b000: taken_d = z_q;
                    3'b001: taken_d = ~z_q;
                    3'b100: taken_d = n_q ^ v_q;
                    3'b101: taken_d = ~(n_q ^ v_q);
                    3'b110: taken_d = ~c_q;
                    3'b111: taken_d = c_q;
                    default: illegal_d = 1'b1;
                endcase
            end
            2'b10, 2'b11: taken_d = 1'b1;
            default: taken_d = 1'b0;
        endcase
        if (kind_q == 2'b11)
            target_d = {alu_q[XLEN-1:1], 1'b0};
        else
            target_d = pc_q + imm_q;
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            kind_q           <= '0;
            funct3_q         <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            alu_q            <= '0;
            z_q              <= 1'b0;
            c_q              <= 1'b0;
            v_q              <= 1'b0;
            n_q              <= 1'b0;
            cnt_q            <= '0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        kind_q     <= br_kind;
                        funct3_q   <= br_funct3;
                        pc_q       <= pc;
                        imm_q      <= imm;
                        alu_q      <= alu_result;
                        z_q        <= flag_zero;
                        c_q        <= flag_carry;
                        v_q        <= flag_overflow;
                        n_q        <= flag_negative;
                        in_ready_q <= 1'b0;
                        state_q    <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    illegal_q <= illegal_d;
                    if (taken_d) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target_d;
                        state_q          <= REDIRECT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            flush_q <= 1'b1;
                            cnt_q   <= CW'(FLUSH_CYCLES - 1);
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        flush_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign illegal_branch = illegal_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] resolved_q;
    logic [31:0] taken_q;

    // Saturating counters of resolved control transfers and taken redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolved_q <= '0;
            taken_q    <= '0;
        end else if (state_q == RESOLVE) begin
            if (kind_q != 2'b00 && resolved_q != 32'hFFFF_FFFF)
                resolved_q <= resolved_q + 32'd1;
            if (taken_d && taken_q != 32'hFFFF_FFFF)
                taken_q <= taken_q + 32'd1;
        end
    end

    assign stat_resolved = resolved_q;
    assign stat_taken    = taken_q;
`endif

endmodule
